// File: rtl/crc_rx_checker.sv
// Serial frame receiver: LSB-first payload, then LSB-first CRC, checked against
// an LFSR-style CRC computed over the payload bits.
module crc_rx_checker #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0]  SEED       = 8'hD8,
    parameter logic [CRC_WIDTH-1:0]  POLY       = 8'h44
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_bit,
    input  logic                  rx_active,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  crc_ok,
    output logic                  crc_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CRC  = 2'd2;

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [DATA_WIDTH-1:0] data_sr_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  done_reg;
    logic                  crc_ok_reg;
    logic                  crc_err_reg;
    logic                  frame_err_reg;
    logic                  mismatch_reg;

    logic [CRC_WIDTH-1:0]  crc_base;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [CRC_WIDTH-1:0]  crc_shifted;
    logic [DATA_WIDTH-1:0] data_sr_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  fb;
    logic                  bit_mismatch;
    logic                  any_mismatch;

    // The first payload bit arrives in IDLE, so the CRC step starts from SEED there.
    assign crc_base = (state_reg == S_IDLE) ? SEED : crc_reg;
    assign fb       = crc_base[0] ^ rx_bit;

    genvar gi;
    generate
        for (gi = 0; gi < CRC_WIDTH - 1; gi++) begin : g_crc_tap
            assign crc_next[gi] = crc_base[gi+1] ^ (fb & POLY[gi]);
        end
    endgenerate
    assign crc_next[CRC_WIDTH-1] = fb;

    generate
        if (DATA_WIDTH == 1) begin : g_sr_one
            assign data_sr_next = rx_bit;
        end else begin : g_sr_wide
            assign data_sr_next = {rx_bit, data_sr_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign cnt_inc      = cnt_reg + CNT_W'(1);
    assign crc_shifted  = crc_reg >> cnt_reg;
    assign bit_mismatch = rx_bit ^ crc_shifted[0];
    assign any_mismatch = mismatch_reg | bit_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            crc_reg       <= SEED;
            data_sr_reg   <= '0;
            data_out_reg  <= '0;
            done_reg      <= 1'b0;
            crc_ok_reg    <= 1'b0;
            crc_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            mismatch_reg  <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            if (rx_active && rx_valid) begin
                frame_err_reg <= 1'b1;
                state_reg     <= S_IDLE;
                cnt_reg       <= '0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DATA: begin
                        if (rx_valid) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= S_IDLE;
                            cnt_reg       <= '0;
                        end else if (rx_active) begin
                            crc_reg     <= crc_next;
                            data_sr_reg <= data_sr_next;
                            if (state_reg == S_IDLE) begin
                                crc_ok_reg   <= 1'b0;
                                crc_err_reg  <= 1'b0;
                                mismatch_reg <= 1'b0;
                            end
                            if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                                state_reg <= S_CRC;
                                cnt_reg   <= '0;
                            end else begin
                                state_reg <= S_DATA;
                                cnt_reg   <= cnt_inc;
                            end
                        end
                    end
                    S_CRC: begin
                        if (rx_active) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= S_IDLE;
                            cnt_reg       <= '0;
                        end else if (rx_valid) begin
                            if (cnt_inc == CNT_W'(CRC_WIDTH)) begin
                                done_reg     <= 1'b1;
                                data_out_reg <= data_sr_reg;
                                crc_ok_reg   <= ~any_mismatch;
                                crc_err_reg  <= any_mismatch;
                                state_reg    <= S_IDLE;
                                cnt_reg      <= '0;
                            end else begin
                                mismatch_reg <= any_mismatch;
                                cnt_reg      <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_out_reg;
    assign done      = done_reg;
    assign crc_ok    = crc_ok_reg;
    assign crc_err   = crc_err_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == S_DATA) || (state_reg == S_CRC);

endmodule

// File: tb/tb_crc_rx_checker.sv
// Directed and randomized frames for crc_rx_checker, checked against a
// whole-frame CRC model and per-frame expectations.
module tb_crc_rx_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_bit;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] data_out;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    crc_rx_checker dut (
        .clk       (clk),
        .rst       (rst),
        .rx_bit    (rx_bit),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .data_out  (data_out),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-payload CRC: reflected shift register, seed 0xD8, taps 0x44.
    function automatic logic [7:0] model_crc(input logic [7:0] pay);
        int c;
        int fb;
        c = 'hD8;
        for (int i = 0; i < 8; i++) begin
            fb = (c ^ (int'(pay) >> i)) & 1;
            c  = c >> 1;
            if (fb != 0) c = c ^ 'h80 ^ 'h44;
        end
        return c[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle past it.
    task automatic cyc(input logic r, input logic a, input logic v, input logic b);
        rst = r; rx_active = a; rx_valid = v; rx_bit = b;
        @(posedge clk);
        #1;
    endtask

    // Sends a frame; gap_d/gap_c name the bit index after which ngap idle cycles go.
    task automatic run_frame(input string tag, input logic [7:0] pay, input logic [7:0] crcv,
                             input int gap_d, input int gap_c, input int ngap,
                             input logic exp_ok);
        int early_done;
        int edges;
        early_done = 0;
        edges      = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, pay[i]);
            edges++;
            early_done += int'(done);
            if (i == gap_d) begin
                for (int g = 0; g < ngap; g++) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                    edges++;
                    early_done += int'(done);
                end
            end
        end
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, crcv[i]);
            edges++;
            if (i < 7) early_done += int'(done);
            if (i == gap_c) begin
                for (int g = 0; g < ngap; g++) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                    edges++;
                    early_done += int'(done);
                end
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_early_done"}, 32'(early_done), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'(pay));
        chk({tag, "_ok"}, 32'(crc_ok), 32'(exp_ok));
        chk({tag, "_err"}, 32'(crc_err), 32'(!exp_ok));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        $display("frame %s payload=%02h crc=%02h edges=%0d done=%0b crc_ok=%0b crc_err=%0b",
                 tag, pay, crcv, edges, done, crc_ok, crc_err);
    endtask

    initial begin
        logic [7:0] pay;
        logic [7:0] crcv;
        logic       good;

        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_outs", {27'd0, done, crc_ok, crc_err, frame_err, busy}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        run_frame("good_00", 8'h00, 8'h14, -1, -1, 0, 1'b1);
        run_frame("bad_00", 8'h00, 8'h15, -1, -1, 0, 1'b0);
        run_frame("gap_00", 8'h00, 8'h14, 4, 2, 3, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("ok_held", 32'(crc_ok), 32'd1);

        // rx_valid during payload after 5 bits of a new frame
        pay = 8'hA5;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, pay[i]);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ferr_data_pulse", 32'(frame_err), 32'd1);
        chk("ferr_data_keep", 32'(data_out), 32'h00);
        chk("ferr_data_flags", {29'd0, done, crc_ok, crc_err}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ferr_data_end", {30'd0, frame_err, busy}, 32'd0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("ferr_idle_valid", {30'd0, frame_err, busy}, 32'd2);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("ferr_both", {30'd0, frame_err, busy}, 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // rx_active during the CRC phase
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ferr_crc_active", {30'd0, frame_err, busy}, 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        run_frame("pre_rst", 8'h00, 8'h14, -1, -1, 0, 1'b1);
        crcv = 8'h14;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, crcv[i]);
        cyc(1'b1, 1'b0, 1'b1, crcv[3]);
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_outs", {27'd0, done, crc_ok, crc_err, frame_err, busy}, 32'd0);
        for (int i = 4; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("midrst_quiet", {29'd0, done, frame_err, busy}, 32'd0);
        end
        run_frame("post_rst", 8'h00, 8'h14, -1, -1, 0, 1'b1);

        run_frame("b2b_a", 8'h00, 8'h14, -1, -1, 0, 1'b1);
        run_frame("b2b_b", 8'h00, 8'h14, -1, -1, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            pay  = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            crcv = model_crc(pay);
            if (!good) crcv = crcv ^ (8'd1 << $urandom_range(0, 7));
            run_frame($sformatf("rand%0d", n), pay, crcv,
                      (n % 3 == 0) ? int'($urandom_range(0, 7)) : -1,
                      (n % 4 == 1) ? int'($urandom_range(0, 6)) : -1,
                      int'($urandom_range(1, 3)), good);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
